// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    MADD  = 3'd2,
    MADDU = 3'd3,
    MSUB  = 3'd4,
    MSUBU = 3'd5,
    DIV   = 3'd6,
    DIVU  = 3'd7
  } mdu_op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL      = 3'd1,
    DIV_INIT = 3'd2,
    DIV_ITER = 3'd3,
    DIV_FIX  = 3'd4,
    DONE     = 3'd5
  } mdu_state_t;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_mode_t;

  function automatic logic is_div(input mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_signed(input mdu_op_t op);
    return (op == MULT) || (op == MADD) || (op == MSUB) || (op == DIV);
  endfunction

  function automatic acc_mode_t acc_mode(input mdu_op_t op);
    acc_mode_t m;
    case (op)
      MADD, MADDU: m = ACC_ADD;
      MSUB, MSUBU: m = ACC_SUB;
      default:     m = ACC_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Radix-2 restoring divider on unsigned magnitudes; the start cycle already
// produces the first quotient bit, so only count-1 further cycles follow.
module div_iter_core #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          flush,
  input  logic [W-1:0]  dvd,
  input  logic [W-1:0]  dvs,
  input  logic [CW-1:0] count,
  output logic          done_c,
  output logic [W-1:0]  quo,
  output logic [W-1:0]  rem
);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          active_q;

  logic [W-1:0]  src_rem, src_quo, src_dvs, nxt_rem, nxt_quo;
  logic [W+1:0]  trial;
  logic          borrow;

  // One shift/subtract step; on start, leading dividend zeros are pre-shifted away.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? (dvd << (CW'(W) - count)) : quo_q;
    src_dvs = start ? dvs : dvs_q;
    trial   = {1'b0, src_rem, src_quo[W-1]} - {2'b00, src_dvs};
    borrow  = trial[W+1];
    nxt_rem = borrow ? {src_rem[W-2:0], src_quo[W-1]} : trial[W-1:0];
    nxt_quo = {src_quo[W-2:0], ~borrow};
    done_c  = active_q && (cnt_q == CW'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (flush) begin
      active_q <= 1'b0;
    end else if (start) begin
      rem_q    <= nxt_rem;
      quo_q    <= nxt_quo;
      dvs_q    <= dvs;
      cnt_q    <= count - CW'(1);
      active_q <= (count != CW'(1));
    end else if (active_q) begin
      rem_q    <= nxt_rem;
      quo_q    <= nxt_quo;
      cnt_q    <= cnt_q - CW'(1);
      active_q <= (cnt_q != CW'(1));
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// EXE-stage multiply/divide unit producing {HI,LO} under valid/ready with flush.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned DIV_EARLY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  mdu_op_t      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] hi_in,
  input  logic [W-1:0] lo_in,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_hi,
  output logic [W-1:0] out_lo,
  output logic         busy
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned MW = 3;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  mdu_state_t state_q, state_d;
  mdu_op_t    op_q;
  logic [W-1:0]  a_q, b_q, hi_q, lo_q;
  logic [MW-1:0] mul_cnt_q;

  logic accept_c, load_mul_c, load_spec_c, load_fix_c, core_start_c, core_done_c;

  assign accept_c = in_valid && in_ready && !flush;

  // Multiply/accumulate; reads the ports in IDLE so MUL_LAT==1 can finish on the accept edge.
  mdu_op_t        m_op;
  logic [W-1:0]   m_a, m_b, m_hi, m_lo;
  logic           m_sgn;
  logic [2*W-1:0] m_ax, m_bx, prod, mul_res;

  always_comb begin
    if (state_q == IDLE) begin
      m_op = op;   m_a = a;   m_b = b;   m_hi = hi_in; m_lo = lo_in;
    end else begin
      m_op = op_q; m_a = a_q; m_b = b_q; m_hi = hi_q;  m_lo = lo_q;
    end
    m_sgn = is_signed(m_op);
    m_ax  = {{W{m_sgn & m_a[W-1]}}, m_a};
    m_bx  = {{W{m_sgn & m_b[W-1]}}, m_b};
    prod  = m_ax * m_bx;
    case (acc_mode(m_op))
      ACC_ADD: mul_res = {m_hi, m_lo} + prod;
      ACC_SUB: mul_res = {m_hi, m_lo} - prod;
      default: mul_res = prod;
    endcase
  end

  // Divide preparation: magnitudes, special cases and iteration count.
  logic          d_sgn, a_neg, b_neg, b_zero, ovf, lz_done;
  logic [W-1:0]  a_mag, b_mag, core_quo, core_rem, q_fix, r_fix;
  logic [CW-1:0] lz, count_c;

  always_comb begin
    d_sgn   = is_signed(op_q);
    a_neg   = d_sgn & a_q[W-1];
    b_neg   = d_sgn & b_q[W-1];
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    b_zero  = (b_q == '0);
    ovf     = d_sgn && (a_q == MIN_VAL) && (b_q == '1);
    lz      = '0;
    lz_done = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!lz_done && !a_mag[i]) lz = lz + CW'(1);
      else lz_done = 1'b1;
    end
    if (DIV_EARLY == 0) count_c = CW'(W);
    else if (lz == CW'(W)) count_c = CW'(1);
    else count_c = CW'(W) - lz;
    q_fix = (a_neg ^ b_neg) ? -core_quo : core_quo;
    r_fix = a_neg ? -core_rem : core_rem;
  end

  div_iter_core #(.W(W), .CW(CW)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (core_start_c),
    .flush  (flush),
    .dvd    (a_mag),
    .dvs    (b_mag),
    .count  (count_c),
    .done_c (core_done_c),
    .quo    (core_quo),
    .rem    (core_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and datapath load strobes; flush overrides everything.
  always_comb begin
    state_d      = state_q;
    load_mul_c   = 1'b0;
    load_spec_c  = 1'b0;
    load_fix_c   = 1'b0;
    core_start_c = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            if (is_div(op)) begin
              state_d = DIV_INIT;
            end else if (MUL_LAT <= 1) begin
              state_d    = DONE;
              load_mul_c = 1'b1;
            end else begin
              state_d = MUL;
            end
          end
        end
        MUL: begin
          if (mul_cnt_q >= MW'(MUL_LAT - 1)) begin
            state_d    = DONE;
            load_mul_c = 1'b1;
          end
        end
        DIV_INIT: begin
          if (b_zero || ovf) begin
            state_d     = DONE;
            load_spec_c = 1'b1;
          end else begin
            core_start_c = 1'b1;
            state_d      = (count_c == CW'(1)) ? DIV_FIX : DIV_ITER;
          end
        end
        DIV_ITER: begin
          if (core_done_c) state_d = DIV_FIX;
        end
        DIV_FIX: begin
          state_d    = DONE;
          load_fix_c = 1'b1;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= MULT;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_cnt_q <= '0;
    end else if (accept_c) begin
      op_q      <= op;
      a_q       <= a;
      b_q       <= b;
      hi_q      <= hi_in;
      lo_q      <= lo_in;
      mul_cnt_q <= MW'(1);
    end else if (state_q == MUL) begin
      mul_cnt_q <= mul_cnt_q + MW'(1);
    end
  end

  // Registered handshake and result outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_hi    <= '0;
      out_lo    <= '0;
    end else begin
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      out_valid <= (state_d == DONE);
      if (load_mul_c) begin
        {out_hi, out_lo} <= mul_res;
      end else if (load_spec_c) begin
        out_hi <= b_zero ? a_q : '0;
        out_lo <= b_zero ? '1 : MIN_VAL;
      end else if (load_fix_c) begin
        out_hi <= r_fix;
        out_lo <= q_fix;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter with a cycle-level reference model and per-cycle compare.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  mdu_op_t     op = MULT;
  logic [31:0] a = '0, b = '0, hi_in = '0, lo_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_hi, out_lo;
  logic        busy;

  int n_run  = 0;
  int n_fail = 0;

  mdu_iter #(.W(32), .MUL_LAT(2), .DIV_EARLY(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .hi_in(hi_in), .lo_in(lo_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_hi(out_hi), .out_lo(out_lo),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Architectural result: {HI,LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input mdu_op_t o, input logic [31:0] x, y, h, l);
    logic [63:0] ps, pu, acc;
    longint      sx, sy, q, r;
    ps  = 64'(longint'($signed(x)) * longint'($signed(y)));
    pu  = {32'd0, x} * {32'd0, y};
    acc = {h, l};
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    case (o)
      MULT:  return ps;
      MULTU: return pu;
      MADD:  return acc + ps;
      MADDU: return acc + pu;
      MSUB:  return acc - ps;
      MSUBU: return acc - pu;
      DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Cycles from the accept cycle to the first out_valid cycle.
  function automatic int lat_of(input mdu_op_t o, input logic [31:0] x, y);
    if (o != DIV && o != DIVU) return 2;
    if (y == 32'd0) return 2;
    if (o == DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  logic        pend = 1'b0;
  int          age = 0;
  int          m_lat = 0;
  logic [63:0] m_res = '0;

  // Transaction-level model of the handshake.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend = 1'b0;
    end else if (flush) begin
      pend = 1'b0;
    end else if (pend) begin
      if (age >= m_lat && out_ready) pend = 1'b0;
      else age++;
    end else if (in_valid) begin
      pend  = 1'b1;
      age   = 1;
      m_res = model(op, a, b, hi_in, lo_in);
      m_lat = lat_of(op, a, b);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("busy", 64'(busy), 64'(pend));
      chk("in_ready", 64'(in_ready), 64'(!pend));
      chk("out_valid", 64'(out_valid), 64'(pend && age >= m_lat));
      if (pend && age >= m_lat) begin
        chk("out_hi", 64'(out_hi), 64'(m_res[63:32]));
        chk("out_lo", 64'(out_lo), 64'(m_res[31:0]));
      end
    end
  end

  task automatic issue(input mdu_op_t o, input logic [31:0] x, y, h, l);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y; hi_in = h; lo_in = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string nm, input mdu_op_t o, input logic [31:0] x, y, h, l,
                        input logic [31:0] ehi, elo, input int elat, input int hold);
    int n;
    issue(o, x, y, h, l);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(elat));
    chk({nm, "_hi"}, 64'(out_hi), 64'(ehi));
    chk({nm, "_lo"}, 64'(out_lo), 64'(elo));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_hi"}, 64'(out_hi), 64'(ehi));
      chk({nm, "_hold_lo"}, 64'(out_lo), 64'(elo));
      chk({nm, "_hold_rdy"}, 64'(in_ready), 64'(0));
      chk({nm, "_hold_busy"}, 64'(busy), 64'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_hi", 64'(out_hi), 64'(0));
    chk("rst_out_lo", 64'(out_lo), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    run_op("mult",  MULT,  32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, 5);
    run_op("maddu", MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 2, 0);
    run_op("msub",  MSUB,  32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);
    run_op("madd",  MADD,  32'hFFFF_FFFF, 32'd4, 32'd0, 32'd10, 32'd0, 32'd6, 2, 0);
    run_op("msubu", MSUBU, 32'd2, 32'd3, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);
    run_op("div",   DIV,   32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0);
    run_op("div_nd", DIV,  32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFD, 34, 2);
    run_op("divu",  DIVU,  32'hFFFF_FFFF, 32'd7, 32'd0, 32'd0, 32'd3, 32'h2492_4924, 34, 0);
    run_op("divu0", DIVU,  32'd100, 32'd0, 32'd0, 32'd0, 32'd100, 32'hFFFF_FFFF, 2, 0);
    run_op("div0",  DIV,   32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 2, 0);
    run_op("ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 2, 0);

    // Request arriving with flush is dropped.
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1; op = MULT; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_req_busy", 64'(busy), 64'(0));

    // Flush in cycle 10 of a divide.
    issue(DIVU, 32'd1000, 32'd3, 32'd0, 32'd0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    chk("flush_busy", 64'(busy), 64'(0));
    repeat (40) begin
      @(posedge clk); #1;
      chk("flush_no_valid", 64'(out_valid), 64'(0));
    end
    run_op("multu", MULTU, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'd15, 2, 0);

    // Asynchronous reset in the middle of a divide.
    issue(DIV, 32'd12345, 32'hFFFF_FFEF, 32'd0, 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_out_hi", 64'(out_hi), 64'(0));
    chk("mid_rst_out_lo", 64'(out_lo), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    run_op("mult2", MULT, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 2, 0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit for the EXE stage.
- Replaces vendor divider IP with a native radix-2 restoring divider and a configurable-latency multiplier.
- Executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU and produces {HI,LO} under a valid/ready handshake with pipeline flush.
- Sits between EXE operand muxes and the HI/LO register file; drives the EXE stall.

Parameters:
- W, 32, operand width; HI/LO are each W bits.
- MUL_LAT, 2, multiply latency in cycles from accept to out_valid (1..4).
- DIV_EARLY, 1, when 1 the divider skips leading-zero dividend bits (early-out); when 0 it uses a fixed iteration count.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept this cycle
- op  in  3  mdu_op_t: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU
- a  in  W  rs operand (dividend / multiplicand)
- b  in  W  rt operand (divisor / multiplier)
- hi_in  in  W  current HI, used by MADD/MSUB
- lo_in  in  W  current LO, used by MADD/MSUB
- flush  in  1  exception/flush; aborts the operation in flight
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_hi  out  W  HI result (product high half or remainder)
- out_lo  out  W  LO result (product low half or quotient)
- busy  out  1  operation accepted and not yet consumed; drives EXE stall

Behaviour:
- Reset (rst=0, async): state=IDLE, in_ready=1, out_valid=0, busy=0, out_hi=out_lo=0, all internal operand and accumulator registers cleared.
- Accept: in_valid && in_ready && !flush. At accept, latch a, b, op, hi_in and lo_in. in_ready=1 only in IDLE.
- FSM states:
  - IDLE: on accept go to MUL (multiply ops) or DIV_INIT (divide ops).
  - MUL: counter runs MUL_LAT-1 cycles, then go to DONE.
  - DIV_INIT: one cycle; take absolute values for DIV; detect b==0 and the MIN/-1 case; both go straight to DONE.
  - DIV_ITER: one quotient bit per cycle, W iterations. With DIV_EARLY, iterations are skipped for leading zeros of |a|.
  - DIV_FIX: one cycle; apply quotient and remainder signs, then go to DONE.
  - DONE: out_valid=1 and results held stable until out_ready, then go to IDLE.
- Latency: multiply = MUL_LAT cycles. Divide = W+2 cycles (DIV_EARLY=0); minimum 3 cycles with early-out.
- Multiply arithmetic:
  - Signed ops sign-extend to W+1 bits; unsigned ops zero-extend; the 2W-bit product is taken from the W+1 by W+1 multiply.
  - MADD*: {hi,lo} = {hi_in,lo_in} + prod.
  - MSUB*: {hi,lo} = {hi_in,lo_in} - prod.
  - Both are mod 2^(2W), with signedness taken from op (MSUBU is unsigned).
- Divide arithmetic:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - b==0: LO = all ones, HI = a.
  - DIV with a = MIN and b = -1: LO = MIN, HI = 0.
- Flush has priority over everything.
  - Any state returns to IDLE on the next edge; out_valid=0 from that edge; the result is discarded.
  - flush together with in_valid: the request is not accepted.
- out_ready while out_valid=0 is ignored.
- busy = (state != IDLE).
- The unit never accepts back-to-back requests in the DONE cycle: IDLE is required before the next accept.

Decomposition:
- mdu_pkg:
  - mdu_op_t, 3-bit enum.
  - mdu_state_t: IDLE, MUL, DIV_INIT, DIV_ITER, DIV_FIX, DONE.
  - Helper functions is_div(op), is_signed(op), acc_mode(op) returning NONE/ADD/SUB.
- Sub-module div_iter_core:
  - Interface: start, flush, unsigned magnitudes, count, done.
  - Holds the restoring shift/subtract datapath and iteration counter; mdu_iter owns sign handling, special cases and the handshake.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=0x00000003, MUL_LAT=2 -> out_valid 2 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MADDU hi_in=0, lo_in=0xFFFFFFFF, a=1, b=1 -> HI=0x00000001, LO=0x00000000. MSUB hi_in=lo_in=0, a=1, b=1 -> HI=LO=0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); with DIV_EARLY=0, out_valid exactly 34 cycles after accept.
- DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Flush in cycle 10 of a DIVU -> state IDLE and in_ready=1 next cycle, out_valid never asserts. A new MULTU 3*5 then gives LO=15, HI=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_hi/out_lo stable, in_ready=0, busy=1. Assert rst mid-DIV -> all outputs at reset values immediately.
